// File: rtl/amber128_fetch.sv
// amber128_fetch: instruction fetch front-end for the 128-bit instruction ROM.
// Issues 16B-aligned addresses, tracks the ROM's one-cycle read latency,
// buffers returned words with their PC and hands them to decode over
// valid/ready. Redirects flush buffered and in-flight words.
// Optional: define AMBER128_FETCH_MISALIGN_CHECK_EN to add fetch_misalign_o,
// a sticky flag raised by a redirect to a non-16B-aligned target.
module amber128_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned C_XLEN     = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [63:0]       imem_addr_o,
    input  logic [C_XLEN-1:0] imem_data_i,
    input  logic              imem_valid_i,
    input  logic              redirect_i,
    input  logic [63:0]       redirect_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [C_XLEN-1:0] instr_o,
    output logic [63:0]       instr_pc_o
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
    ,
    output logic              fetch_misalign_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [63:0]       pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [63:0]       inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  credit;
    logic              push, pop, drop, issue;

    logic [C_XLEN-1:0] mem_data_q [FIFO_DEPTH];
    logic [63:0]       mem_pc_q   [FIFO_DEPTH];

    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? mem_data_q[rptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? mem_pc_q[rptr_q]   : '0;
    assign credit        = count_q + CNT_W'(inflight_q);

    // Next-state: redirect beats a dropped return, which beats a new issue.
    always_comb begin
        push          = inflight_q && imem_valid_i && !redirect_i;
        drop          = inflight_q && !imem_valid_i && !redirect_i;
        pop           = instr_valid_o && instr_ready_i;
        // A dropped word rewinds pc_q, so nothing newer may be issued behind it.
        issue         = (credit < DEPTH_C) && !redirect_i && !drop;

        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;

        if (redirect_i) begin
            pc_d    = redirect_pc_i & ~64'hF;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (drop) begin
                pc_d = inflight_pc_q;
            end else if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 64'd16;
            end
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wptr_q] <= imem_data_i;
            mem_pc_q[wptr_q]   <= inflight_pc_q;
        end
    end

`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign fetch_misalign_o = misalign_q;

    // Sticky flag for redirects to non-aligned targets.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[3:0] != 4'h0)) begin
            misalign_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_amber128_fetch.sv
// Directed bench for amber128_fetch: streaming, back-pressure, redirects,
// ROM-valid drop/rewind, PC wrap-around and mid-stream reset.
module tb_amber128_fetch;

    logic         clk;
    logic         rst_n;
    logic         ready;
    logic         redirect;
    logic [63:0]  redirect_pc;
    logic         stall;

    logic [63:0]  addr, addr_w;
    logic [127:0] rom_d, rom_w_d;
    logic         rom_v, rom_w_v;
    logic         imem_valid;
    logic         ivalid, ivalid_w;
    logic [127:0] instr, instr_w;
    logic [63:0]  ipc, ipc_w;
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
    logic         mis, mis_w;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [127:0] rom_word(input logic [63:0] a);
        return {~a, a ^ 64'h5A5A_0F0F_C3C3_9669};
    endfunction

    amber128_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr), .imem_data_i(rom_d),
        .imem_valid_i(imem_valid), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(ivalid), .instr_ready_i(ready), .instr_o(instr), .instr_pc_o(ipc)
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        , .fetch_misalign_o(mis)
`endif
    );

    amber128_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFE0), .FIFO_DEPTH(4)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr_w), .imem_data_i(rom_w_d),
        .imem_valid_i(rom_w_v), .redirect_i(1'b0), .redirect_pc_i(64'h0),
        .instr_valid_o(ivalid_w), .instr_ready_i(1'b1), .instr_o(instr_w), .instr_pc_o(ipc_w)
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        , .fetch_misalign_o(mis_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: registered read, valid low for the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_v   <= 1'b0;
            rom_d   <= '0;
            rom_w_v <= 1'b0;
            rom_w_d <= '0;
        end else begin
            rom_v   <= 1'b1;
            rom_d   <= rom_word(addr);
            rom_w_v <= 1'b1;
            rom_w_d <= rom_word(addr_w);
        end
    end

    assign imem_valid = rom_v && !stall;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after release.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;

        // Streaming from reset, plus wrap-around instance.
        do_reset();
        chk("rst_addr",   128'(addr),   128'(64'h0));
        chk("rst_valid",  128'(ivalid), 128'(1'b0));
        chk("rst_instr",  instr,        128'h0);
        chk("rst_pc",     128'(ipc),    128'(64'h0));
        chk("rst_addr_w", 128'(addr_w), 128'(64'hFFFF_FFFF_FFFF_FFE0));
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        chk("rst_mis",    128'(mis),    128'(1'b0));
`endif
        tick();
        chk("c1_addr",  128'(addr),   128'(64'h10));
        chk("c1_valid", 128'(ivalid), 128'(1'b0));
        for (int c = 2; c <= 6; c++) begin
            logic [63:0] ep, epw;
            tick();
            ep  = 64'(c - 2) * 64'h10;
            epw = 64'hFFFF_FFFF_FFFF_FFE0 + ep;
            chk("str_valid", 128'(ivalid),   128'(1'b1));
            chk("str_pc",    128'(ipc),      128'(ep));
            chk("str_data",  instr,          rom_word(ep));
            chk("str_addr",  128'(addr),     128'(ep + 64'h20));
            chk("wrap_pc",   128'(ipc_w),    128'(epw));
            chk("wrap_data", instr_w,        rom_word(epw));
        end

        // Back-pressure: fill the FIFO, then drain in order.
        ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 10; c++) tick();
        chk("full_addr",  128'(addr),   128'(64'h40));
        chk("full_valid", 128'(ivalid), 128'(1'b1));
        chk("full_pc",    128'(ipc),    128'(64'h0));
        ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("drain_valid", 128'(ivalid), 128'(1'b1));
            chk("drain_pc",    128'(ipc),    128'(64'(i) * 64'h10));
            chk("drain_data",  instr,        rom_word(64'(i) * 64'h10));
        end

        // Redirect with three buffered entries.
        ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 4; c++) tick();
        chk("pre_rd_pc", 128'(ipc), 128'(64'h0));
        redirect    = 1'b1;
        redirect_pc = 64'h1000;
        tick();
        redirect = 1'b0;
        chk("rd1_valid", 128'(ivalid), 128'(1'b0));
        chk("rd1_addr",  128'(addr),   128'(64'h1000));
        tick();
        chk("rd2_valid", 128'(ivalid), 128'(1'b0));
        tick();
        chk("rd3_valid", 128'(ivalid), 128'(1'b1));
        chk("rd3_pc",    128'(ipc),    128'(64'h1000));
        ready = 1'b1;
        tick();
        chk("rd4_pc", 128'(ipc), 128'(64'h1010));
        tick();
        chk("rd5_pc", 128'(ipc), 128'(64'h1020));
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        chk("mis_aligned", 128'(mis), 128'(1'b0));
`endif

        // Redirect coincident with a pop, misaligned target.
        redirect    = 1'b1;
        redirect_pc = 64'h2008;
        tick();
        redirect = 1'b0;
        chk("rp1_valid", 128'(ivalid), 128'(1'b0));
        chk("rp1_addr",  128'(addr),   128'(64'h2000));
        tick();
        chk("rp2_valid", 128'(ivalid), 128'(1'b0));
        tick();
        chk("rp3_valid", 128'(ivalid), 128'(1'b1));
        chk("rp3_pc",    128'(ipc),    128'(64'h2000));
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        chk("mis_set", 128'(mis), 128'(1'b1));
`endif

        // ROM valid low for one return: word dropped and refetched.
        tick();
        chk("dr0_pc", 128'(ipc), 128'(64'h2010));
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("dr1_valid", 128'(ivalid), 128'(1'b0));
        chk("dr1_addr",  128'(addr),   128'(64'h2020));
        tick();
        chk("dr2_valid", 128'(ivalid), 128'(1'b0));
        tick();
        chk("dr3_valid", 128'(ivalid), 128'(1'b1));
        chk("dr3_pc",    128'(ipc),    128'(64'h2020));
        chk("dr3_data",  instr,        rom_word(64'h2020));
        tick();
        chk("dr4_pc", 128'(ipc), 128'(64'h2030));

        // Mid-stream reset with a full FIFO.
        ready = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        chk("mf_addr",  128'(addr),   128'(64'h2070));
        chk("mf_valid", 128'(ivalid), 128'(1'b1));
        chk("mf_pc",    128'(ipc),    128'(64'h2030));
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 128'(ivalid), 128'(1'b0));
        chk("mr_pc",    128'(ipc),    128'(64'h0));
        chk("mr_instr", instr,        128'h0);
        chk("mr_addr",  128'(addr),   128'(64'h0));
`ifdef AMBER128_FETCH_MISALIGN_CHECK_EN
        chk("mr_mis",   128'(mis),    128'(1'b0));
`endif
        tick();
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        chk("ma1_valid", 128'(ivalid), 128'(1'b0));
        tick();
        chk("ma2_valid", 128'(ivalid), 128'(1'b1));
        chk("ma2_pc",    128'(ipc),    128'(64'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
